// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: hold levels, instruction address width, FSM states.
// Consumed by pipe_ctrl, its watchdog and the stage registers that decode hold_flag.
package pipe_ctrl_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned WdogW       = 16;
  localparam int unsigned FlushCntW   = 4;

  typedef logic [InstAddrBus-1:0] inst_addr_t;

  typedef enum logic [2:0] {
    Hold_None = 3'd0,
    Hold_Pc   = 3'd1,
    Hold_If   = 3'd2,
    Hold_Id   = 3'd3
  } hold_e;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } pipe_state_e;

  function automatic hold_e hold_max(input hold_e a, input hold_e b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/control bundle between the hold requesters (ex, rib, clint) and pipe_ctrl.
// Perf counter outputs exist only when PIPE_CTRL_PERF_EN is defined.
interface pipe_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic       jump_flag_i;
  inst_addr_t jump_addr_i;
  logic       hold_flag_ex_i;
  logic       hold_flag_rib_i;
  logic       hold_flag_clint_i;

  logic [2:0] hold_flag_o;
  logic       jump_flag_o;
  inst_addr_t jump_addr_o;
  logic       bus_timeout_o;
  logic       flushing_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt_o;
  logic [31:0] perf_flush_cnt_o;
`endif

  modport master (
    output jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i, hold_flag_clint_i,
    input  hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o, flushing_o
`ifdef PIPE_CTRL_PERF_EN
    , input perf_stall_cnt_o, perf_flush_cnt_o
`endif
  );

  modport slave (
    input  jump_flag_i, jump_addr_i, hold_flag_ex_i, hold_flag_rib_i, hold_flag_clint_i,
    output hold_flag_o, jump_flag_o, jump_addr_o, bus_timeout_o, flushing_o
`ifdef PIPE_CTRL_PERF_EN
    , output perf_stall_cnt_o, perf_flush_cnt_o
`endif
  );

endinterface

// File: rtl/pipe_ctrl_wdog.sv
// Bus-hold watchdog: counts consecutive held cycles and pulses once per hold
// when the count reaches BUS_TIMEOUT-1; never releases the hold itself.
module pipe_ctrl_wdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic hold_i,
  output logic timeout_o
);

  localparam logic [WdogW-1:0] Limit   = BUS_TIMEOUT[WdogW-1:0];
  localparam logic [WdogW-1:0] LimitM1 = Limit - 16'd1;

  logic [WdogW-1:0] cnt_q;

  // Counter parks at Limit, one past the trigger value, so the pulse fires once per hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_o <= 1'b0;
    end else begin
      timeout_o <= hold_i && (cnt_q == LimitM1);
      if (!hold_i) begin
        cnt_q <= '0;
      end else if (cnt_q != Limit) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges ex/rib/clint holds with ex jumps into hold_flag, stretches
// the post-jump flush window, and watches rib holds. Optional PIPE_CTRL_PERF_EN adds perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned BUS_TIMEOUT  = 1024
) (
  input  logic            clk,
  input  logic            rst,
  pipe_ctrl_if.slave      ctrl
);

  localparam bit          FlushEn      = (FLUSH_CYCLES > 1);
  localparam int unsigned FlushReloadI = FlushEn ? (FLUSH_CYCLES - 2) : 0;
  localparam logic [FlushCntW-1:0] FlushReload = FlushReloadI[FlushCntW-1:0];

  logic                 out_en_q;
  pipe_state_e          state_q;
  logic [FlushCntW-1:0] flush_cnt_q;
  logic                 jump;
  hold_e                hold;

  // Requests are masked until the first edge after reset release, keeping all outputs idle
  // for that cycle; afterwards the jump path is a pure combinational copy.
  assign jump = ctrl.jump_flag_i & out_en_q;

  always_comb begin
    hold = Hold_None;
    if (ctrl.hold_flag_rib_i && out_en_q) begin
      hold = Hold_Pc;
    end
    if (jump || ((ctrl.hold_flag_ex_i || ctrl.hold_flag_clint_i) && out_en_q) || (state_q == FLUSH)) begin
      hold = hold_max(hold, Hold_Id);
    end
  end

  assign ctrl.hold_flag_o = hold;
  assign ctrl.jump_flag_o = jump;
  assign ctrl.jump_addr_o = jump ? ctrl.jump_addr_i : '0;
  assign ctrl.flushing_o  = (state_q == FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_en_q    <= 1'b0;
      state_q     <= RUN;
      flush_cnt_q <= '0;
    end else begin
      out_en_q <= 1'b1;
      unique case (state_q)
        RUN: begin
          if (jump && FlushEn) begin
            state_q     <= FLUSH;
            flush_cnt_q <= FlushReload;
          end
        end
        FLUSH: begin
          if (jump) begin
            flush_cnt_q <= FlushReload;
          end else if (flush_cnt_q == '0) begin
            state_q <= RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q - 4'd1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  pipe_ctrl_wdog #(
    .BUS_TIMEOUT(BUS_TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .hold_i   (ctrl.hold_flag_rib_i & out_en_q),
    .timeout_o(ctrl.bus_timeout_o)
  );

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl.perf_stall_cnt_o <= '0;
      ctrl.perf_flush_cnt_o <= '0;
    end else begin
      if (hold != Hold_None) begin
        ctrl.perf_stall_cnt_o <= ctrl.perf_stall_cnt_o + 32'd1;
      end
      if (jump) begin
        ctrl.perf_flush_cnt_o <= ctrl.perf_flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule
